// File: rtl/uart_bridge_pkg.sv
// Shared definitions for the UART-to-bus bridge: FSM state encoding and
// the command / reply byte values exchanged over the UART.
package uart_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_ADDR = 3'd1,
        GET_DATA = 3'd2,
        BUS_WR   = 3'd3,
        BUS_RD   = 3'd4,
        SEND     = 3'd5
    } state_t;

    localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
    localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'
    localparam logic [7:0] RSP_OK    = 8'h4B;  // 'K'
    localparam logic [7:0] RSP_BAD   = 8'h3F;  // '?'
    localparam logic [7:0] RSP_ERR   = 8'h45;  // 'E'

    // True for the two opcodes that start a bus transaction.
    function automatic logic is_command(input logic [7:0] b);
        return (b == CMD_WRITE) || (b == CMD_READ);
    endfunction

endpackage

// File: rtl/uart_bus_bridge.sv
// UART-to-bus bridge. Accepts 'W' addr[4] data[4] or 'R' addr[4] (little
// endian) from a UART receiver, performs one bus access and replies through
// the UART transmitter ('K', four read bytes, 'E' on read timeout, '?' on an
// unknown opcode).
//
// Handshakes:
//   rx: rx_pop is a one-cycle request issued only while rx_available is high
//       and no pop is outstanding; the byte is taken on the first cycle rx_ack
//       is high afterwards. rx_ack with no pop outstanding is ignored.
//   tx: tx_available/tx_data are held until tx_ack; tx_available drops the
//       cycle after tx_ack, then rises again with the next reply byte.
//   bus: writes are a single mem_en cycle; reads hold mem_en until read_ack
//       or until TIMEOUT cycles have elapsed (read_ack wins a tie).
// The FSM state is held in the `state` register for external checkers.
module uart_bus_bridge
    import uart_bridge_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_available,
    input  logic [7:0]  rx_data,
    output logic        rx_pop,
    input  logic        rx_ack,
    output logic        tx_available,
    output logic [7:0]  tx_data,
    input  logic        tx_ack,
    output logic        mem_en,
    output logic        mem_read,
    output logic [31:0] addr,
    output logic [31:0] data_out,
    input  logic [31:0] data_in,
    input  logic        read_ack
);

    localparam int                 TIMER_W    = $clog2(TIMEOUT + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    state_t             state;
    state_t             state_next;
    logic               pop_pending;  // rx_pop issued, waiting for rx_ack
    logic               byte_done;    // a fetched byte is on rx_data this cycle
    logic               fetch_state;  // states that consume UART bytes
    logic               rd_timeout;   // last permitted cycle of a bus read
    logic [1:0]         byte_cnt;
    logic               is_read;
    logic [TIMER_W-1:0] timer;
    logic [31:0]        reply_buf;
    logic [1:0]         reply_idx;
    logic [1:0]         reply_last;

    assign byte_done   = pop_pending && rx_ack;
    assign fetch_state = state inside {IDLE, GET_ADDR, GET_DATA};
    assign rd_timeout  = (timer == TIMER_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state decode and bus strobes (bus strobes follow the state directly
    // so reset drops them on the reset edge).
    always_comb begin
        state_next = state;
        mem_en     = 1'b0;
        mem_read   = 1'b0;
        case (state)
            IDLE: begin
                if (byte_done) state_next = is_command(rx_data) ? GET_ADDR : SEND;
            end
            GET_ADDR: begin
                if (byte_done && byte_cnt == 2'd3) state_next = is_read ? BUS_RD : GET_DATA;
            end
            GET_DATA: begin
                if (byte_done && byte_cnt == 2'd3) state_next = BUS_WR;
            end
            BUS_WR: begin
                mem_en     = 1'b1;
                state_next = SEND;
            end
            BUS_RD: begin
                mem_en   = 1'b1;
                mem_read = 1'b1;
                if (read_ack || rd_timeout) state_next = SEND;
            end
            SEND: begin
                if (tx_available && tx_ack && reply_idx == reply_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Byte fetch, address/data collection, read timer and reply sequencing.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_pop       <= 1'b0;
            pop_pending  <= 1'b0;
            tx_available <= 1'b0;
            tx_data      <= 8'h00;
            addr         <= 32'h0;
            data_out     <= 32'h0;
            byte_cnt     <= 2'd0;
            is_read      <= 1'b0;
            timer        <= '0;
            reply_buf    <= 32'h0;
            reply_idx    <= 2'd0;
            reply_last   <= 2'd0;
        end else begin
            rx_pop <= 1'b0;
            if (fetch_state && !pop_pending && rx_available) begin
                rx_pop      <= 1'b1;
                pop_pending <= 1'b1;
            end else if (byte_done) begin
                pop_pending <= 1'b0;
            end

            if (state == BUS_RD) timer <= timer + TIMER_W'(1);
            else                 timer <= '0;

            case (state)
                IDLE: begin
                    if (byte_done) begin
                        is_read  <= (rx_data == CMD_READ);
                        byte_cnt <= 2'd0;
                        if (!is_command(rx_data)) begin
                            reply_buf    <= {24'h0, RSP_BAD};
                            reply_idx    <= 2'd0;
                            reply_last   <= 2'd0;
                            tx_available <= 1'b1;
                            tx_data      <= RSP_BAD;
                        end
                    end
                end
                GET_ADDR: begin
                    if (byte_done) begin
                        addr[{byte_cnt, 3'b000} +: 8] <= rx_data;
                        byte_cnt                      <= byte_cnt + 2'd1;
                    end
                end
                GET_DATA: begin
                    if (byte_done) begin
                        data_out[{byte_cnt, 3'b000} +: 8] <= rx_data;
                        byte_cnt                          <= byte_cnt + 2'd1;
                    end
                end
                BUS_WR: begin
                    reply_buf    <= {24'h0, RSP_OK};
                    reply_idx    <= 2'd0;
                    reply_last   <= 2'd0;
                    tx_available <= 1'b1;
                    tx_data      <= RSP_OK;
                end
                BUS_RD: begin
                    if (read_ack) begin
                        reply_buf    <= data_in;
                        reply_idx    <= 2'd0;
                        reply_last   <= 2'd3;
                        tx_available <= 1'b1;
                        tx_data      <= data_in[7:0];
                    end else if (rd_timeout) begin
                        reply_buf    <= {24'h0, RSP_ERR};
                        reply_idx    <= 2'd0;
                        reply_last   <= 2'd0;
                        tx_available <= 1'b1;
                        tx_data      <= RSP_ERR;
                    end
                end
                SEND: begin
                    if (tx_available && tx_ack) begin
                        tx_available <= 1'b0;
                        reply_idx    <= reply_idx + 2'd1;
                    end else if (!tx_available) begin
                        tx_available <= 1'b1;
                        tx_data      <= reply_buf[{reply_idx, 3'b000} +: 8];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Bench for uart_bus_bridge: UART rx/tx responders, a bus responder/monitor,
// and a transaction-level reference model that turns each command into the
// expected bus access and expected reply bytes.
module tb_uart_bus_bridge;

    localparam int         TIMEOUT = 255;
    localparam logic [7:0] C_W     = 8'h57;
    localparam logic [7:0] C_R     = 8'h52;
    localparam logic [7:0] R_K     = 8'h4B;
    localparam logic [7:0] R_Q     = 8'h3F;
    localparam logic [7:0] R_E     = 8'h45;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_available;
    logic [7:0]  rx_data;
    logic        rx_pop;
    logic        rx_ack;
    logic        tx_available;
    logic [7:0]  tx_data;
    logic        tx_ack;
    logic        mem_en;
    logic        mem_read;
    logic [31:0] addr;
    logic [31:0] data_out;
    logic [31:0] data_in;
    logic        read_ack;

    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_exp_t;
    typedef struct { logic [31:0] addr; int len; } rd_exp_t;

    logic [7:0]  exp_q[$];   // expected tx reply bytes
    logic [7:0]  rx_q[$];    // bytes waiting in the model UART receiver
    wr_exp_t     exp_wr_q[$];
    rd_exp_t     exp_rd_q[$];

    int          checks       = 0;
    int          errors       = 0;
    int          rd_delay     = -1;
    logic [31:0] rd_value     = 32'h0;
    int          tx_delay     = -1;
    int          extra_tx     = 0;
    int          extra_bus    = 0;
    int          rx_underflow = 0;
    int          excl_err     = 0;
    int          rd_addr_move = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    uart_bus_bridge #(.TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_available (rx_available),
        .rx_data      (rx_data),
        .rx_pop       (rx_pop),
        .rx_ack       (rx_ack),
        .tx_available (tx_available),
        .tx_data      (tx_data),
        .tx_ack       (tx_ack),
        .mem_en       (mem_en),
        .mem_read     (mem_read),
        .addr         (addr),
        .data_out     (data_out),
        .data_in      (data_in),
        .read_ack     (read_ack)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- UART receiver model ----------------
    initial begin
        int d;
        rx_ack       = 1'b0;
        rx_data      = 8'h00;
        rx_available = 1'b0;
        forever begin
            @(posedge clk); #1;
            rx_ack = 1'b0;
            if (rx_pop) begin
                d = $urandom_range(0, 2);
                repeat (d) begin @(posedge clk); #1; end
                if (rx_q.size() == 0) rx_underflow++;
                else begin
                    rx_data = rx_q.pop_front();
                    rx_ack  = 1'b1;
                end
            end
            rx_available = (rx_q.size() != 0);
        end
    end

    // ---------------- UART transmitter model + reply scoreboard ----------------
    initial begin
        int d;
        logic [7:0] held;
        tx_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            tx_ack = 1'b0;
            if (tx_available && !rst) begin
                held = tx_data;
                d = (tx_delay >= 0) ? tx_delay : int'($urandom_range(0, 3));
                repeat (d) begin
                    @(posedge clk); #1;
                    check("tx_hold_data", 32'(tx_data), 32'(held));
                    check("tx_hold_valid", 32'(tx_available), 32'd1);
                end
                tx_ack = 1'b1;
                if (exp_q.size() == 0) extra_tx++;
                else check("tx_byte", 32'(held), 32'(exp_q.pop_front()));
                @(posedge clk); #1;
                tx_ack = 1'b0;
                check("tx_release", 32'(tx_available), 32'd0);
            end
        end
    end

    // ---------------- bus responder / monitor ----------------
    initial begin
        int      wr_run;
        int      rd_run;
        rd_exp_t cur;
        wr_exp_t w;
        logic    have_cur;
        wr_run   = 0;
        rd_run   = 0;
        have_cur = 1'b0;
        read_ack = 1'b0;
        data_in  = 32'h0;
        forever begin
            @(posedge clk); #1;
            read_ack = 1'b0;
            data_in  = $urandom;
            if (rx_pop && (mem_en || tx_available)) excl_err++;
            if (mem_en && !mem_read) begin
                if (wr_run == 0) begin
                    if (exp_wr_q.size() == 0) extra_bus++;
                    else begin
                        w = exp_wr_q.pop_front();
                        check("wr_addr", addr, w.addr);
                        check("wr_data", data_out, w.data);
                    end
                end
                wr_run++;
            end else if (wr_run != 0) begin
                check("wr_len", wr_run, 32'd1);
                wr_run = 0;
            end
            if (mem_en && mem_read) begin
                if (rd_run == 0) begin
                    if (exp_rd_q.size() == 0) begin
                        extra_bus++;
                        have_cur = 1'b0;
                    end else begin
                        cur      = exp_rd_q.pop_front();
                        have_cur = 1'b1;
                        check("rd_addr", addr, cur.addr);
                    end
                end else if (have_cur && addr !== cur.addr) begin
                    rd_addr_move++;
                end
                rd_run++;
                if (rd_delay >= 0 && rd_run == rd_delay + 1) begin
                    read_ack = 1'b1;
                    data_in  = rd_value;
                end
            end else if (rd_run != 0) begin
                if (have_cur) check("rd_len", rd_run, cur.len);
                rd_run   = 0;
                have_cur = 1'b0;
            end
        end
    end

    // ---------------- driver tasks + reference model ----------------
    task automatic push_word(input logic [31:0] v);
        for (int i = 0; i < 4; i++) rx_q.push_back(8'(v >> (8 * i)));
    endtask

    // Queue one command and record what it must produce.
    task automatic issue(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d,
                         input int delay, input logic [31:0] rval);
        wr_exp_t w;
        rd_exp_t r;
        rx_q.push_back(cmd);
        if (cmd == C_W || cmd == C_R) push_word(a);
        if (cmd == C_W) begin
            push_word(d);
            w.addr = a;
            w.data = d;
            exp_wr_q.push_back(w);
            exp_q.push_back(R_K);
        end else if (cmd == C_R) begin
            rd_delay = delay;
            rd_value = rval;
            r.addr   = a;
            if (delay >= 0 && delay < TIMEOUT) begin
                r.len = delay + 1;
                for (int i = 0; i < 4; i++) exp_q.push_back(8'(rval >> (8 * i)));
            end else begin
                r.len = TIMEOUT;
                exp_q.push_back(R_E);
            end
            exp_rd_q.push_back(r);
        end else begin
            exp_q.push_back(R_Q);
        end
    endtask

    task automatic wait_idle(input string tag);
        int   n;
        logic busy;
        n    = 0;
        busy = 1'b1;
        while (busy && n < 3000) begin
            @(posedge clk); #1;
            n++;
            busy = (rx_q.size() != 0) || (exp_q.size() != 0) || (exp_wr_q.size() != 0) ||
                   (exp_rd_q.size() != 0) || tx_available || mem_en || rx_pop || rx_ack;
        end
        repeat (3) @(posedge clk);
        #1;
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_pop"}, 32'(rx_pop), 32'd0);
        check({tag, "_tx_available"}, 32'(tx_available), 32'd0);
        check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        check({tag, "_mem_en"}, 32'(mem_en), 32'd0);
        check({tag, "_mem_read"}, 32'(mem_read), 32'd0);
        check({tag, "_addr"}, addr, 32'd0);
        check({tag, "_data_out"}, data_out, 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          n;
        logic [7:0]  b;
        int          sel;
        int          delay;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        issue(C_W, 32'h0000_0100, 32'hDEAD_BEEF, -1, 32'h0);
        wait_idle("idle_write");
        issue(C_R, 32'h0000_0104, 32'h0, 3, 32'h1234_5678);
        wait_idle("idle_read");
        issue(C_R, 32'h0000_0200, 32'h0, -1, 32'h0);
        wait_idle("idle_timeout");
        issue(C_R, 32'h0000_0204, 32'h0, TIMEOUT - 1, 32'hCAFE_F00D);
        wait_idle("idle_ack_at_limit");
        issue(8'h41, 32'h0, 32'h0, -1, 32'h0);
        issue(C_W, 32'h0000_0300, 32'h0BAD_F00D, -1, 32'h0);
        wait_idle("idle_bad_then_write");
        tx_delay = 10;
        issue(C_R, 32'h0000_0400, 32'h0, 1, 32'hA5C3_1E7F);
        wait_idle("idle_backpressure");
        tx_delay = -1;

        // Reset while collecting write data: no reply, outputs cleared.
        rx_q.push_back(C_W);
        push_word(32'h0000_0500);
        rx_q.push_back(8'h11);
        rx_q.push_back(8'h22);
        n = 0;
        while ((rx_q.size() != 0 || rx_pop || rx_ack) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("rx_drain", 32'(rx_q.size()), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("rst_get_data");
        rst = 1'b0;
        repeat (30) @(posedge clk);
        issue(C_W, 32'h0000_0600, 32'h7654_3210, -1, 32'h0);
        wait_idle("idle_after_reset");

        // Reset during a bus read: mem_en drops on the reset edge, no reply.
        begin
            rd_exp_t r;
            rd_delay = -1;
            rx_q.push_back(C_R);
            push_word(32'h0000_0700);
            r.addr = 32'h0000_0700;
            r.len  = 21;
            exp_rd_q.push_back(r);
            n = 0;
            while (!(mem_en && mem_read) && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
            repeat (20) begin @(posedge clk); #1; end
            rst = 1'b1;
            @(posedge clk); #1;
            check("rst_rd_mem_en", 32'(mem_en), 32'd0);
            rst = 1'b0;
            wait_idle("idle_after_rd_reset");
        end

        // Randomized commands against the reference model.
        repeat (14) begin
            sel = $urandom_range(0, 4);
            if (sel == 0) begin
                do b = 8'($urandom_range(0, 255)); while (b == C_W || b == C_R);
                issue(b, 32'h0, 32'h0, -1, 32'h0);
            end else if (sel <= 2) begin
                issue(C_W, $urandom, $urandom, -1, 32'h0);
            end else begin
                n = $urandom_range(0, 9);
                if (n < 7)       delay = $urandom_range(0, 12);
                else if (n == 7) delay = TIMEOUT - 1;
                else if (n == 8) delay = TIMEOUT;
                else             delay = -1;
                issue(C_R, $urandom, 32'h0, delay, $urandom);
            end
            wait_idle("idle_rand");
        end

        check("extra_tx", extra_tx, 32'd0);
        check("extra_bus", extra_bus, 32'd0);
        check("rx_underflow", rx_underflow, 32'd0);
        check("exclusive", excl_err, 32'd0);
        check("rd_addr_stable", rd_addr_move, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_bus_bridge.md
UART_BUS_BRIDGE -- requirements
Module: uart_bus_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum cycles to wait for read_ack.
REQ-002 SHALL have port clk, input, 1: single clock for all logic.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port rx_available, input, 1: UART receiver holds a byte.
REQ-005 SHALL have port rx_data, input, 8: received byte, valid when rx_ack is high.
REQ-006 SHALL have port rx_pop, output, 1: one-cycle request to consume a byte.
REQ-007 SHALL have port rx_ack, input, 1: pop completed, rx_data valid this cycle.
REQ-008 SHALL have port tx_available, output, 1: byte offered to UART transmitter.
REQ-009 SHALL have port tx_data, output, 8: byte to transmit.
REQ-010 SHALL have port tx_ack, input, 1: transmitter accepted tx_data.
REQ-011 SHALL have port mem_en, output, 1: bus access strobe.
REQ-012 SHALL have port mem_read, output, 1: 1 = read access, 0 = write access.
REQ-013 SHALL have port addr, output, 32: bus byte address.
REQ-014 SHALL have port data_out, output, 32: write data.
REQ-015 SHALL have port data_in, input, 32: read data, valid when read_ack is high.
REQ-016 SHALL have port read_ack, input, 1: read data valid.

Function
REQ-017 SHALL implement states IDLE, GET_ADDR, GET_DATA, BUS_WR, BUS_RD, SEND, plus a pop-wait sub-phase for every byte fetch.
REQ-018 SHALL fetch each byte as follows: while rx_available is high and no pop is outstanding, pulse rx_pop for exactly 1 cycle, then capture rx_data on the first cycle rx_ack is high.
REQ-019 SHALL, in IDLE, decode the fetched byte: 0x57 'W' goes to GET_ADDR (write), 0x52 'R' goes to GET_ADDR (read), and any other byte queues reply 0x3F '?' and enters SEND.
REQ-020 SHALL, in GET_ADDR, collect 4 bytes little-endian into addr; after the 4th byte, a write goes to GET_DATA and a read goes to BUS_RD.
REQ-021 SHALL, in GET_DATA, collect 4 bytes little-endian into data_out, then go to BUS_WR.
REQ-022 SHALL, in BUS_WR, assert mem_en=1 and mem_read=0 for exactly one cycle, then queue reply 0x4B 'K' and enter SEND.
REQ-023 SHALL, in BUS_RD, hold mem_en=1 and mem_read=1 until read_ack; on read_ack, capture data_in, drop mem_en the next cycle, and queue 4 reply bytes little-endian.
REQ-024 SHALL, when read_ack stays low for TIMEOUT cycles in BUS_RD, drop mem_en and queue single reply 0x45 'E'.
REQ-025 SHALL, in SEND, hold tx_available high with tx_data stable until tx_ack, deassert tx_available the cycle after tx_ack, advance to the next queued byte, and return to IDLE after the last byte.
REQ-026 SHALL hold addr and data_out stable from command completion through the end of the bus access.
REQ-027 SHALL, when read_ack arrives on the same cycle the timeout expires, treat the access as a success.
REQ-028 SHALL ignore read_ack outside BUS_RD, and ignore rx_ack when no pop is outstanding.
REQ-029 SHALL keep mem_en and tx_available mutually exclusive with rx_pop in every cycle.

Reset
REQ-030 SHALL, while rst is high at a clk edge, enter IDLE and drive rx_pop=0, tx_available=0, tx_data=0, mem_en=0, mem_read=0, addr=0, data_out=0, and clear the byte counter and timeout counter.
REQ-031 SHALL, when rst is asserted mid-command or mid-bus-read, abandon the transaction with no reply and drop mem_en on the reset edge.

Structure
REQ-032 SHALL take command and reply byte constants (0x57, 0x52, 0x4B, 0x3F, 0x45) and the state encoding from shared package uart_bridge_pkg.
REQ-033 SHALL be implemented as a single module with no sub-modules.

Verification
REQ-034 SHALL verify write: bytes 57 00 01 00 00 EF BE AD DE -> one cycle of mem_en=1, mem_read=0, addr=0x100, data_out=0xDEADBEEF, then tx byte 0x4B.
REQ-035 SHALL verify read: bytes 52 04 01 00 00 with read_ack 3 cycles later and data_in=0x12345678 -> tx bytes 78 56 34 12 in order.
REQ-036 SHALL verify timeout: read command with read_ack never asserted -> mem_en drops after 255 cycles, tx byte 0x45.
REQ-037 SHALL verify bad command: byte 0x41 -> tx byte 0x3F with no mem_en activity, then a following valid write still succeeds.
REQ-038 SHALL verify backpressure and reset: tx_ack delayed 10 cycles keeps tx_data stable throughout; rst pulsed during GET_DATA gives all outputs 0 on the next cycle and no reply.
